fetch_ctrl: RTL and testbench

Program-sequencing controller that owns the program counter and decides, each cycle, whether the core fetches, branches, flushes or stops. Sits between the testbench/top-level start handshake and the instruction memory address bus. Resolves arithmetic branches through a small programmable offset table, inserts a one-cycle bubble after every taken branch, and reports completion and cycle count.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/branch_lut.sv | 47 ++++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-sequencing controller: state encoding,
// opcode field positions and the taken-branch decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

  localparam int INSTR_W      = 9;
  localparam logic [INSTR_W-1:0] HALT_OP = 9'h1FF;

  localparam int BR_CLASS_BIT = 8;
  localparam int BR_EN_BIT    = 6;
  localparam int BR_IDX_HI    = 5;
  localparam int BR_IDX_LO    = 3;

  localparam int LUT_DEPTH    = 8;
  localparam int LUT_IDX_W    = 3;

  // Branch class bit clear, branch enable set, and the ALU reports equality.
  function automatic logic is_taken_branch(input logic [INSTR_W-1:0] instr,
                                           input logic                equal);
    return (~instr[BR_CLASS_BIT]) & instr[BR_EN_BIT] & equal;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch offset table: LUT_DEPTH signed offsets, one synchronous write port
// and one asynchronous read port that sees the pre-write value in a write cycle.
module branch_lut
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);

  localparam logic [PC_W-1:0] OFF_POS2 = PC_W'(2);
  localparam logic [PC_W-1:0] OFF_NEG2 = PC_W'(0) - PC_W'(2);

  logic [PC_W-1:0] mem_q [LUT_DEPTH];
  logic [PC_W-1:0] mem_d [LUT_DEPTH];

  // Next table contents: a single entry may be replaced per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Table storage; reset reloads the +2 / -2 defaults at the two ends.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= (i == 0)             ? OFF_POS2 :
                    (i == LUT_DEPTH - 1) ? OFF_NEG2 : PC_W'(0);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// Program-sequencing controller: owns the PC, resolves table-driven branches
// with a one-cycle bubble, and reports completion plus a saturating cycle count.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W    = 10,
  parameter logic [PC_W-1:0] LAST_PC = 10'd1023,
  parameter int              CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 init_n,
  input  logic                 start,
  input  logic [INSTR_W-1:0]   instruction,
  input  logic                 EQUAL,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_addr,
  input  logic [PC_W-1:0]      lut_data,
  output logic [PC_W-1:0]      PC,
  output logic                 fetch_en,
  output logic                 busy,
  output logic                 done,
  output logic                 halt,
  output logic [CNT_W-1:0]     cycle_count
);

  fc_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             done_q, done_d;
  logic             lut_we_ok_s;
  logic [PC_W-1:0]  lut_off_s;

  branch_lut #(
    .PC_W(PC_W)
  ) u_branch_lut (
    .clk   (CLK),
    .init_n(init_n),
    .we    (lut_we_ok_s),
    .waddr (lut_addr),
    .wdata (lut_data),
    .raddr (instruction[BR_IDX_HI:BR_IDX_LO]),
    .rdata (lut_off_s)
  );

  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, PC and counter decode; priority in RUN is halt, branch, last PC.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    lut_we_ok_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        lut_we_ok_s = lut_we;
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        cnt_d = cnt_inc_s;
        if (instruction == HALT_OP) begin
          state_d = DONE;
        end else if (is_taken_branch(instruction, EQUAL)) begin
          // Offset is PC-wide two's complement, so plain addition wraps correctly.
          state_d = FLUSH;
          pc_d    = pc_q + lut_off_s;
        end else if (pc_q == LAST_PC) begin
          state_d = DONE;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      FLUSH: begin
        cnt_d   = cnt_inc_s;
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!init_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign PC          = pc_q;
  assign fetch_en    = (state_q == RUN);
  assign busy        = (state_q == RUN) || (state_q == FLUSH);
  assign halt        = (state_q == DONE);
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// programs, all compared cycle by cycle against an abstract run/bubble model.
module tb_fetch_ctrl;

  localparam int              PC_W    = 10;
  localparam logic [PC_W-1:0] LAST    = 10'd20;
  localparam int              CNT_W   = 5;
  localparam int              CNT_MAX = 31;
  localparam int              MEM_N   = 1024;

  logic             CLK = 1'b0;
  logic             init_n, start, EQUAL, lut_we;
  logic [2:0]       lut_addr;
  logic [PC_W-1:0]  lut_data;
  logic [8:0]       instruction;
  logic [PC_W-1:0]  PC;
  logic             fetch_en, busy, done, halt;
  logic [CNT_W-1:0] cycle_count;

  logic [8:0] imem [MEM_N];

  int n_tests = 0;
  int n_fail  = 0;

  // Abstract model: running / in bubble / halted, with integer PC and count.
  bit m_active, m_bubble, m_halted, m_done;
  int m_pc, m_cnt;
  int m_lut [8];

  always #5 CLK = ~CLK;

  assign instruction = imem[PC];

  fetch_ctrl #(.PC_W(PC_W), .LAST_PC(LAST), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .init_n(init_n), .start(start), .instruction(instruction),
    .EQUAL(EQUAL), .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .PC(PC), .fetch_en(fetch_en), .busy(busy), .done(done), .halt(halt),
    .cycle_count(cycle_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_bubble = 1'b0; m_halted = 1'b0; m_done = 1'b0;
    m_pc = 0; m_cnt = 0;
    m_lut = '{2, 0, 0, 0, 0, 0, 0, -2};
  endtask

  task automatic model_finish();
    m_active = 1'b0; m_bubble = 1'b0; m_halted = 1'b1; m_done = 1'b1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    logic [8:0] ins;
    if (!init_n) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (lut_we) m_lut[lut_addr] = int'($signed(lut_data));
        if (start) begin
          m_active = 1'b1; m_bubble = 1'b0; m_halted = 1'b0;
          m_pc = 0; m_cnt = 0;
        end
      end else begin
        m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (m_bubble) begin
          m_bubble = 1'b0;
        end else begin
          ins = imem[m_pc];
          if (ins == 9'h1FF) begin
            model_finish();
          end else if (ins[8] == 1'b0 && ins[6] == 1'b1 && EQUAL) begin
            m_pc = (((m_pc + m_lut[ins[5:3]]) % MEM_N) + MEM_N) % MEM_N;
            m_bubble = 1'b1;
          end else if (m_pc == int'(LAST)) begin
            model_finish();
          end else begin
            m_pc = (m_pc + 1) % MEM_N;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pc",       32'(PC),          32'(m_pc));
    check_eq("fetch_en", 32'(fetch_en),    32'(m_active && !m_bubble));
    check_eq("busy",     32'(busy),        32'(m_active));
    check_eq("halt",     32'(halt),        32'(m_halted));
    check_eq("done",     32'(done),        32'(m_done));
    check_eq("cnt",      32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
    compare_all();
    init_n = 1'b1; start = 1'b0; lut_we = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_end(input int budget);
    for (int i = 0; i < budget && busy; i++) cycle();
    check_eq("end_timeout", 32'(busy), 32'd0);
  endtask

  task automatic write_lut(input logic [2:0] a, input int off);
    lut_we = 1'b1; lut_addr = a; lut_data = PC_W'(off);
    cycle();
  endtask

  initial begin
    logic [8:0] r;
    for (int a = 0; a < MEM_N; a++) imem[a] = 9'h000;
    init_n = 1'b0; start = 1'b0; EQUAL = 1'b0; lut_we = 1'b0;
    lut_addr = 3'd0; lut_data = '0;
    model_reset();

    // Reset state
    cycle();
    check_eq("rst_pc", 32'(PC), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    cycles(2);

    // NOP program to LAST: 21 executed instructions
    start = 1'b1; cycle();
    check_eq("start_pc0", 32'(PC), 32'd0);
    run_to_end(60);
    check_eq("nop_done", 32'(done), 32'd1);
    check_eq("nop_pc", 32'(PC), 32'd20);
    check_eq("nop_cnt", 32'(cycle_count), 32'd21);
    cycle();
    check_eq("nop_done_drop", 32'(done), 32'd0);
    check_eq("nop_halt", 32'(halt), 32'd1);

    // Branch idx 0 (+2) at PC 3, taken then not taken
    imem[3] = 9'h040; EQUAL = 1'b1;
    start = 1'b1; cycle(); cycles(3);
    cycle();
    check_eq("br_flush_fe", 32'(fetch_en), 32'd0);
    check_eq("br_flush_pc", 32'(PC), 32'd5);
    cycle();
    check_eq("br_target_fe", 32'(fetch_en), 32'd1);
    run_to_end(60);
    EQUAL = 1'b0;
    start = 1'b1; cycle(); cycles(4);
    check_eq("nobr_pc", 32'(PC), 32'd4);
    check_eq("nobr_fe", 32'(fetch_en), 32'd1);
    run_to_end(60);
    imem[3] = 9'h000;

    // lut[2] = -3, branch at PC 7 -> 4; write during run dropped
    write_lut(3'd2, -3);
    imem[7] = 9'h050; EQUAL = 1'b1;
    start = 1'b1; cycle(); cycles(7);
    check_eq("lut_br_at7", 32'(PC), 32'd7);
    cycle();
    check_eq("lut_br_pc", 32'(PC), 32'd4);
    lut_we = 1'b1; lut_addr = 3'd2; lut_data = 10'd5;
    cycle(); cycles(3);
    cycle();
    check_eq("lut_drop_pc", 32'(PC), 32'd4);
    init_n = 1'b0; cycle();
    imem[7] = 9'h000;

    // Halt opcode at PC 2, then restart
    imem[2] = 9'h1FF; EQUAL = 1'b0;
    start = 1'b1; cycle();
    run_to_end(20);
    check_eq("halt_pc", 32'(PC), 32'd2);
    check_eq("halt_done", 32'(done), 32'd1);
    cycle();
    start = 1'b1; cycle();
    check_eq("restart_pc", 32'(PC), 32'd0);
    check_eq("restart_cnt", 32'(cycle_count), 32'd0);
    run_to_end(20);
    imem[2] = 9'h000;

    // Wrap: 0 + (-2) -> 1022, 1023 + 2 -> 1
    imem[0] = 9'h078; imem[1023] = 9'h040; EQUAL = 1'b1;
    start = 1'b1; cycle(); cycle();
    check_eq("wrap_neg", 32'(PC), 32'd1022);
    cycles(3);
    check_eq("wrap_pos", 32'(PC), 32'd1);
    check_eq("wrap_pos_fe", 32'(fetch_en), 32'd0);
    run_to_end(60);
    imem[0] = 9'h000; imem[1023] = 9'h000;

    // Zero offset at PC 9: RUN/FLUSH loop, saturation, start ignored, reset mid-FLUSH
    imem[9] = 9'h048; EQUAL = 1'b1;
    start = 1'b1; cycle(); cycles(20);
    start = 1'b1; cycle(); cycles(20);
    check_eq("loop_pc", 32'(PC), 32'd9);
    check_eq("sat_cnt", 32'(cycle_count), 32'd31);
    for (int i = 0; i < 4 && fetch_en; i++) cycle();
    check_eq("loop_in_flush", 32'(fetch_en), 32'd0);
    init_n = 1'b0; cycle();
    check_eq("rst_mid_pc", 32'(PC), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_cnt", 32'(cycle_count), 32'd0);
    check_eq("rst_mid_halt", 32'(halt), 32'd0);
    imem[9] = 9'h000;

    // Randomized programs and control traffic
    for (int run = 0; run < 30; run++) begin
      for (int a = 0; a < MEM_N; a++) begin
        if ($urandom_range(0, 39) == 0) begin
          imem[a] = 9'h1FF;
        end else begin
          r = 9'($urandom_range(0, 510));
          if ($urandom_range(0, 4) == 0) r = {1'b0, r[7], 1'b1, r[5:0]};
          imem[a] = r;
        end
      end
      for (int k = 0; k < 3; k++) write_lut(3'($urandom_range(0, 7)), $urandom_range(0, 10) - 5);
      start = 1'b1; cycle();
      for (int c = 0; c < 150; c++) begin
        EQUAL    = 1'($urandom_range(0, 1));
        start    = ($urandom_range(0, 15) == 0);
        lut_we   = ($urandom_range(0, 15) == 0);
        lut_addr = 3'($urandom_range(0, 7));
        lut_data = PC_W'($urandom_range(0, 10) - 5);
        init_n   = ($urandom_range(0, 127) != 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
